shift_cmd_stage: RTL and testbench

- Registered command front-end for the 32-bit left/right rotator (`multifunction_shifter_32`), which it instantiates internally.
- Accepts rotate commands (operand, amount, direction) over a valid/ready handshake and buffers them in a small FIFO.
- Feeds one command per cycle to the combinational rotator.
- Captures each result in an output register with its own valid/ready handshake, so the rotator can sit between two pipelined blocks without combinational paths crossing them.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/multifunction_shifter_32.sv | 25 ++
 rtl/shift_cmd_fifo.sv | 56 +++++
 rtl/shift_cmd_stage.sv | 102 ++++++++++
 tb/tb_shift_cmd_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants and the command record for the rotate command stage.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int AMT_W   = 5;
    localparam int ENTRY_W = DATA_W + AMT_W + 1;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // One queued rotate command; packed so a FIFO slot is exactly ENTRY_W bits.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [AMT_W-1:0]  amt;
        logic              lr;
    } shift_cmd_t;

    // Builds a command record from its three fields.
    function automatic shift_cmd_t make_cmd(input logic [DATA_W-1:0] a,
                                            input logic [AMT_W-1:0]  amt,
                                            input logic              lr);
        shift_cmd_t c;
        c.a   = a;
        c.amt = amt;
        c.lr  = lr;
        return c;
    endfunction

endpackage

// File: rtl/multifunction_shifter_32.sv
// Combinational 32-bit rotator: lr = 0 rotates right, lr = 1 rotates left.
// amt is naturally modulo 32 by its width; amt = 0 passes a through.
import shift_pkg::*;

module multifunction_shifter_32 (
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              lr,
    output logic [DATA_W-1:0] y
);

    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] shr;
    logic [2*DATA_W-1:0] shl;

    // Rotate by shifting a doubled copy: the low half of a right shift and the
    // high half of a left shift are the rotated words, with no amt = 0 special case.
    always_comb begin
        dbl = {a, a};
        shr = dbl >> amt;
        shl = dbl << amt;
        y   = (lr == DIR_LEFT) ? shl[2*DATA_W-1:DATA_W] : shr[DATA_W-1:0];
    end

endmodule

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO with head-of-queue read (rd_data shows the oldest
// entry whenever not empty). Pointers wrap modulo DEPTH; count is AW+1 bits.
import shift_pkg::*;

module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  shift_cmd_t    wr_data,
    input  logic          pop,
    output shift_cmd_t    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    shift_cmd_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset: a slot is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shift_cmd_stage.sv
// Registered command front-end around the 32-bit rotator: commands queue in a
// small FIFO, one per cycle goes through the rotator, and the result lands in
// an output register with its own valid/ready.
// Optional: define SHIFT_CMD_STATS_EN to add the done_count result counter.
import shift_pkg::*;

module shift_cmd_stage #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic              in_lr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_lr,
`ifdef SHIFT_CMD_STATS_EN
    output logic [AMT_W-1:0]  out_amt,
    output logic [15:0]       done_count
`else
    output logic [AMT_W-1:0]  out_amt
`endif
);

    shift_cmd_t        in_cmd;
    shift_cmd_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rot_y;

    // Occupancy is kept on the FIFO for debug visibility; the stage itself only
    // needs full/empty.
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;

    assign in_cmd   = make_cmd(in_a, in_amt, in_lr);
    // Readiness depends only on FIFO state, never on out_ready.
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    // Advance the head whenever the output register is free or being drained.
    assign pop      = ~fifo_empty & (~out_valid | out_ready);

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (in_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    multifunction_shifter_32 u_rot (
        .a   (head.a),
        .amt (head.amt),
        .lr  (head.lr),
        .y   (rot_y)
    );

    // Output register: load on pop, clear valid on a drain with nothing behind
    // it, otherwise hold (covers the stalled case). out_y keeps its last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_amt   <= '0;
            out_lr    <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_y     <= rot_y;
            out_amt   <= head.amt;
            out_lr    <= head.lr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SHIFT_CMD_STATS_EN
    // Count delivered results; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_count <= '0;
        end else if (out_valid & out_ready) begin
            done_count <= done_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_cmd_stage.sv
// Self-checking bench for shift_cmd_stage: table of single-command vectors,
// then backpressure fill/drain, streaming, random backpressure and reset flush.
module tb_shift_cmd_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_amt;
    logic        in_lr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_lr;
    logic [4:0]  out_amt;
`ifdef SHIFT_CMD_STATS_EN
    logic [15:0] done_count;
`endif

    int errors = 0;
    int checks = 0;

    shift_cmd_stage #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_lr     (in_lr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_lr    (out_lr),
`ifdef SHIFT_CMD_STATS_EN
        .out_amt   (out_amt),
        .done_count(done_count)
`else
        .out_amt   (out_amt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  amt;
        logic        lr;
        logic [31:0] exp_y;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rotate, one bit position per step.
    function automatic logic [31:0] rot_ref(input logic [31:0] a, input logic [4:0] amt,
                                            input logic lr);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < int'(amt); i++)
            r = lr ? {r[30:0], r[31]} : {r[0], r[31:1]};
        return r;
    endfunction

    // Packs {y, amt, lr} of a command for whole-result comparisons.
    function automatic logic [63:0] exp_rec(input logic [31:0] a, input logic [4:0] amt,
                                            input logic lr);
        return {26'd0, rot_ref(a, amt, lr), amt, lr};
    endfunction

    function automatic logic [63:0] out_rec();
        return {26'd0, out_y, out_amt, out_lr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rdy_now;
        logic        vld_now;
        int          acc;
        int          p;
        int          r;
        int          first_cyc;
        int          last_cyc;
        int          sent;
        int          got;
        int          cyc;
        logic [63:0] q[$];
        logic [63:0] exp_v;
        logic [31:0] fa;
        logic [4:0]  fm;
        logic        fl;

        vecs[0] = '{32'h80000001, 5'd1,  1'b0, 32'hC0000000};
        vecs[1] = '{32'h80000001, 5'd4,  1'b1, 32'h00000018};
        vecs[2] = '{32'h12345678, 5'd0,  1'b0, 32'h12345678};
        vecs[3] = '{32'h12345678, 5'd0,  1'b1, 32'h12345678};
        vecs[4] = '{32'h12345678, 5'd4,  1'b0, 32'h81234567};
        vecs[5] = '{32'h12345678, 5'd8,  1'b1, 32'h34567812};
        vecs[6] = '{32'h00000001, 5'd31, 1'b1, 32'h80000000};
        vecs[7] = '{32'h00000001, 5'd31, 1'b0, 32'h00000002};
        vecs[8] = '{32'hF0000000, 5'd16, 1'b0, 32'h0000F000};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_amt = '0; in_lr = 1'b0; out_ready = 1'b1;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_y",     64'(out_y),     64'd0);
        check("rst out_amt",   64'(out_amt),   64'd0);
        check("rst out_lr",    64'(out_lr),    64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst in_ready", 64'(in_ready), 64'd1);
`ifdef SHIFT_CMD_STATS_EN
        check("rst done_count", 64'(done_count), 64'd0);
`endif

        // Table vectors: one command at a time with the consumer always ready.
        foreach (vecs[i]) begin
            check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
            in_valid = 1'b1; in_a = vecs[i].a; in_amt = vecs[i].amt; in_lr = vecs[i].lr;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d early valid", i), 64'(out_valid), 64'd0);
            tick();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d out_y", i),     64'(out_y),     64'(vecs[i].exp_y));
            check($sformatf("vec%0d out_amt", i),   64'(out_amt),   64'(vecs[i].amt));
            check($sformatf("vec%0d out_lr", i),    64'(out_lr),    64'(vecs[i].lr));
            tick();
            check($sformatf("vec%0d drained", i), 64'(out_valid), 64'd0);
        end

        // Fill under backpressure: exactly DEPTH + 1 accepted, output stays on first.
        out_ready = 1'b0;
        acc = 0;
        for (int it = 0; it < 10; it++) begin
            in_valid = 1'b1;
            in_a = 32'hA5000000 | acc; in_amt = 5'(acc * 3 + 1); in_lr = acc[0];
            rdy_now = in_ready;
            tick();
            if (rdy_now) acc++;
            if (it >= 1)
                check("fill stall y", out_rec(), exp_rec(32'hA5000000, 5'd1, 1'b0));
        end
        in_valid = 1'b0;
        check("fill accepted", 64'(acc), 64'd5);
        check("fill in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("drain%0d rec", k), out_rec(),
                  exp_rec(32'hA5000000 | k, 5'(k * 3 + 1), k[0]));
            tick();
        end
        check("drain empty", 64'(out_valid), 64'd0);

        // Streaming: one push and one result per cycle, order preserved.
        p = 0; r = 0; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            vld_now = (p < 16);
            in_valid = vld_now;
            in_a = 32'h01234567 + 32'(p) * 32'h11111111; in_amt = 5'(p * 7); in_lr = p[1];
            rdy_now = in_ready;
            tick();
            if (vld_now && rdy_now) p++;
            if (out_valid) begin
                check($sformatf("stream%0d rec", r), out_rec(),
                      exp_rec(32'h01234567 + 32'(r) * 32'h11111111, 5'(r * 7), r[1]));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                r++;
            end
        end
        in_valid = 1'b0;
        check("stream pushed", 64'(p), 64'd16);
        check("stream results", 64'(r), 64'd16);
        check("stream no bubble", 64'(last_cyc - first_cyc), 64'd15);
`ifdef SHIFT_CMD_STATS_EN
        check("done_count", 64'(done_count), 64'd30);
`endif

        // Random traffic and backpressure against a scoreboard.
        sent = 0; got = 0; cyc = 0;
        while (got < 200 && cyc < 5000) begin
            in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            fa = $urandom; fm = 5'($urandom_range(0, 31)); fl = 1'($urandom_range(0, 1));
            in_a = fa; in_amt = fm; in_lr = fl;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand spurious", out_rec(), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_v = q.pop_front();
                    check($sformatf("rand%0d rec", got), out_rec(), exp_v);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(exp_rec(fa, fm, fl));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("rand received", 64'(got), 64'd200);
        check("rand leftover", 64'(q.size()), 64'd0);

        // Reset with a full output register and 3 queued commands.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();   // let any residue drain
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_a = 32'hDEAD0000 | k; in_amt = 5'd3; in_lr = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("pre-rst valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("rst async valid", 64'(out_valid), 64'd0);
        check("rst async y", 64'(out_y), 64'd0);
        #2;
        reset = 1'b0;
        tick();
        check("post-rst in_ready", 64'(in_ready), 64'd1);
`ifdef SHIFT_CMD_STATS_EN
        check("post-rst done_count", 64'(done_count), 64'd0);
`endif
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("post-rst stale%0d", k), 64'(out_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
